config_reg_bank: RTL and testbench
==================================

// Module: config_reg_bank
//
// PURPOSE
//   Parametrised, addressable bank of configuration registers for core
//   generators. Replaces per-register instances plus a combinational read mux.
//   Adds a shadow/active double buffer with an atomic commit, dirty tracking,
//   and a registered read path with a valid strobe.
//   Sits between the tile config bus and the core datapath; the datapath
//   consumes config_out.
//
// PARAMETERS
//   NUM_REGS     4   number of registers, 1..256
//   DATA_WIDTH   32  register and config-bus data width
//   ADDR_WIDTH   8   config-bus address width
//   BASE_ADDR    0   address of register 0; register i is at BASE_ADDR+i
//   INIT_VALUE   0   reset value of every shadow and active register
//   DOUBLE_BUF   1   1: writes land in shadow, active updates on commit
//                    0: direct mode, writes update active immediately
//
// PORTS
//   clk                 in   1                    clock, all flops posedge
//   reset               in   1                    synchronous, active-high
//   config_config_addr  in   ADDR_WIDTH           register address
//   config_config_data  in   DATA_WIDTH           write data
//   config_read         in   1                    read strobe, 1-cycle pulse
//   config_write        in   1                    write strobe, 1-cycle pulse
//   config_commit       in   1                    copy shadow->active (DOUBLE_BUF=1)
//   read_config_data    out  DATA_WIDTH           registered read data
//   read_valid          out  1                    read_config_data valid this cycle
//   config_out          out  NUM_REGS*DATA_WIDTH  active regs; reg i at [i*DW +: DW]
//   commit_pending      out  1                    OR of all dirty bits
//
// BEHAVIOUR
//   - Reset (sync, dominates all inputs):
//       shadow[i] = active[i] = INIT_VALUE, dirty = 0,
//       read_config_data = 0, read_valid = 0, commit_pending = 0.
//       A read issued in the cycle before reset produces no read_valid.
//   - Decode: idx = addr - BASE_ADDR, computed in ADDR_WIDTH+1 bits.
//       hit iff BASE_ADDR <= addr < BASE_ADDR+NUM_REGS.
//       Address arithmetic never wraps: addresses below BASE_ADDR miss.
//   - Write, hit: shadow[idx] <= data next edge.
//       DOUBLE_BUF=1: dirty[idx] <= 1.
//       DOUBLE_BUF=0: active[idx] <= data too; dirty stays 0.
//   - Write, miss: ignored, no state change.
//   - Read: latency 1.
//       Edge after config_read=1: read_valid=1 for exactly one cycle.
//       read_config_data = shadow[idx] sampled before any same-cycle write.
//       Miss returns 0 and still pulses read_valid.
//       read_config_data holds its value when read_valid=0.
//   - Read and write in the same cycle: both are honoured. The read returns
//     the pre-write value; the write takes effect.
//   - Commit (DOUBLE_BUF=1): at the next edge active[i] <= shadow[i] for all
//     i, and dirty <= 0. This is atomic: all registers change on one edge.
//     Commit in DOUBLE_BUF=0: ignored.
//   - Write and commit in the same cycle: commit copies the pre-write
//     shadow. The written register gets the new shadow value, keeps its old
//     active value, and ends with dirty[idx]=1.
//   - commit_pending is registered and equals |dirty after each edge.
//   - config_out is driven directly from the active flops (no extra latency).
//     It changes only on a commit, a direct-mode write, or reset.
//   - No back-pressure. Back-to-back reads and writes every cycle are
//     supported at full rate.
//
// TESTING
//   1. Reset defaults: INIT_VALUE=32'hA5, NUM_REGS=4; assert reset 2 cycles
//      -> config_out = 4x 32'hA5, read_valid=0, commit_pending=0.
//   2. Shadow isolation (DOUBLE_BUF=1, BASE_ADDR=8'h10):
//      write 8'h12 <- 32'hDEADBEEF -> config_out[2] unchanged, commit_pending=1;
//      read 8'h12 -> next cycle read_valid=1, data 32'hDEADBEEF.
//   3. Atomic commit: write regs 0 and 3, then pulse config_commit
//      -> both config_out slices update on the same edge, commit_pending=0.
//   4. Collisions: in one cycle, read and write 8'h11 <- 32'h5 with commit=1
//      -> read returns the old value; active[1] = old shadow;
//      shadow[1] = 5; commit_pending=1.
//   5. Decode boundaries: read 8'h0F, then 8'h14 -> read_valid=1, data 0;
//      write 8'h14 -> no state change.
//      DOUBLE_BUF=0: write 8'h10 <- 7 -> config_out[0]=7 next cycle.
//   6. Reset mid-operation: config_read=1, then reset=1 on the next cycle
//      -> read_valid stays 0, all state returns to INIT_VALUE.

Source files
------------

// File: rtl/config_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : config_reg_bank
// Description : Addressable configuration register bank with shadow/active
//               double buffering, atomic commit and registered read path.
// Revision    : 1.0 - initial release
// ============================================================================
module config_reg_bank #(
    parameter int                    NUM_REGS   = 4,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    BASE_ADDR  = 0,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
    parameter int                    DOUBLE_BUF = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [ADDR_WIDTH-1:0]          config_config_addr,
    input  logic [DATA_WIDTH-1:0]          config_config_data,
    input  logic                           config_read,
    input  logic                           config_write,
    input  logic                           config_commit,
    output logic [DATA_WIDTH-1:0]          read_config_data,
    output logic                           read_valid,
    output logic [NUM_REGS*DATA_WIDTH-1:0] config_out,
    output logic                           commit_pending
);

    localparam int               c_IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH:0] c_BASE = (ADDR_WIDTH+1)'(BASE_ADDR);
    localparam logic             c_DBUF  = (DOUBLE_BUF != 0);

    logic [DATA_WIDTH-1:0] r_shadow [NUM_REGS];
    logic [DATA_WIDTH-1:0] r_active [NUM_REGS];
    logic [NUM_REGS-1:0]   r_dirty;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;
    logic                  r_commit_pending;

    logic [ADDR_WIDTH:0]   w_addr_ext;
    logic [ADDR_WIDTH:0]   w_off;
    logic [c_IDX_W-1:0]    w_idx;
    logic                  w_hit;
    logic                  w_wr;
    logic                  w_commit;
    logic [NUM_REGS-1:0]   w_dirty_next;

    // Zero-extended subtraction: addresses below the base underflow into the
    // top bit and are rejected by the explicit lower-bound compare.
    assign w_addr_ext = {1'b0, config_config_addr};
    assign w_off      = w_addr_ext - c_BASE;
    assign w_idx      = w_off[c_IDX_W-1:0];
    assign w_hit      = (w_addr_ext >= c_BASE) && (32'(w_off) < 32'(NUM_REGS));
    assign w_wr       = config_write && w_hit;
    assign w_commit   = config_commit && c_DBUF;

    always_comb begin
        w_dirty_next = r_dirty;
        if (w_commit) begin
            w_dirty_next = '0;
        end
        // A write landing with a commit re-dirties its register.
        if (w_wr && c_DBUF) begin
            w_dirty_next[w_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_shadow[i] <= INIT_VALUE;
                r_active[i] <= INIT_VALUE;
            end
            r_dirty          <= '0;
            r_rd_data        <= '0;
            r_rd_valid       <= 1'b0;
            r_commit_pending <= 1'b0;
        end else begin
            r_rd_valid <= config_read;
            if (config_read) begin
                r_rd_data <= w_hit ? r_shadow[w_idx] : '0;
            end
            if (w_commit) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    r_active[i] <= r_shadow[i];
                end
            end
            if (w_wr) begin
                r_shadow[w_idx] <= config_config_data;
                if (!c_DBUF) begin
                    r_active[w_idx] <= config_config_data;
                end
            end
            r_dirty          <= w_dirty_next;
            r_commit_pending <= |w_dirty_next;
        end
    end

    generate
        for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
            assign config_out[g*DATA_WIDTH +: DATA_WIDTH] = r_active[g];
        end
    endgenerate

    // A read strobe in the cycle before reset must never surface as valid.
    assign read_valid       = r_rd_valid & ~reset;
    assign read_config_data = r_rd_data;
    assign commit_pending   = r_commit_pending;

endmodule
`default_nettype wire

// File: tb/tb_config_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_config_reg_bank
// Description : Directed self-checking bench for config_reg_bank.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_config_reg_bank;

    logic         clk;
    logic         reset;
    logic [7:0]   addr;
    logic [31:0]  wdata;
    logic         rd;
    logic         wr;
    logic         cm;

    logic [31:0]  rdata0, rdata1;
    logic         rvalid0, rvalid1;
    logic [127:0] cout0, cout1;
    logic         pend0, pend1;

    int total = 0;
    int bad   = 0;

    config_reg_bank #(
        .NUM_REGS(4), .DATA_WIDTH(32), .ADDR_WIDTH(8), .BASE_ADDR(8'h10),
        .INIT_VALUE(32'hA5), .DOUBLE_BUF(1)
    ) dut (
        .clk(clk), .reset(reset), .config_config_addr(addr),
        .config_config_data(wdata), .config_read(rd), .config_write(wr),
        .config_commit(cm), .read_config_data(rdata0), .read_valid(rvalid0),
        .config_out(cout0), .commit_pending(pend0)
    );

    config_reg_bank #(
        .NUM_REGS(4), .DATA_WIDTH(32), .ADDR_WIDTH(8), .BASE_ADDR(8'h10),
        .INIT_VALUE(32'hA5), .DOUBLE_BUF(0)
    ) dut_direct (
        .clk(clk), .reset(reset), .config_config_addr(addr),
        .config_config_data(wdata), .config_read(rd), .config_write(wr),
        .config_commit(cm), .read_config_data(rdata1), .read_valid(rvalid1),
        .config_out(cout1), .commit_pending(pend1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; addr = '0; wdata = '0; rd = 0; wr = 0; cm = 0;
        tick();
        tick();
        reset = 1'b0;

        // Reset defaults
        chk("rst_cout",   cout0, {4{32'hA5}});
        chk("rst_valid",  128'(rvalid0), 128'(0));
        chk("rst_pend",   128'(pend0), 128'(0));
        chk("rst_rdata",  128'(rdata0), 128'(0));

        // Shadow isolation
        addr = 8'h12; wdata = 32'hDEADBEEF; wr = 1;
        tick();
        wr = 0;
        chk("shadow_cout",   cout0, {4{32'hA5}});
        chk("shadow_pend",   128'(pend0), 128'(1));
        chk("direct_wr2",    cout1, {32'hA5, 32'hDEADBEEF, 32'hA5, 32'hA5});
        chk("direct_pend",   128'(pend1), 128'(0));
        rd = 1;
        tick();
        rd = 0;
        chk("rd12_valid", 128'(rvalid0), 128'(1));
        chk("rd12_data",  128'(rdata0), 128'(32'hDEADBEEF));
        tick();
        chk("rd_pulse_end", 128'(rvalid0), 128'(0));
        chk("rd_hold",      128'(rdata0), 128'(32'hDEADBEEF));

        // Atomic commit
        addr = 8'h10; wdata = 32'h11111111; wr = 1;
        tick();
        addr = 8'h13; wdata = 32'h33333333;
        tick();
        wr = 0;
        chk("pre_commit", cout0, {4{32'hA5}});
        cm = 1;
        tick();
        cm = 0;
        chk("commit_cout", cout0, {32'h33333333, 32'hDEADBEEF, 32'hA5, 32'h11111111});
        chk("commit_pend", 128'(pend0), 128'(0));
        chk("direct_commit_ign", cout1, {32'h33333333, 32'hDEADBEEF, 32'hA5, 32'h11111111});

        // Collision: read + write + commit on the same register
        addr = 8'h11; wdata = 32'h22222222; wr = 1;
        tick();
        wdata = 32'h5; rd = 1; cm = 1;
        tick();
        wr = 0; rd = 0; cm = 0;
        chk("coll_valid", 128'(rvalid0), 128'(1));
        chk("coll_rdata", 128'(rdata0), 128'(32'h22222222));
        chk("coll_cout",  cout0, {32'h33333333, 32'hDEADBEEF, 32'h22222222, 32'h11111111});
        chk("coll_pend",  128'(pend0), 128'(1));
        chk("coll_direct", cout1, {32'h33333333, 32'hDEADBEEF, 32'h5, 32'h11111111});
        rd = 1;
        tick();
        rd = 0;
        chk("coll_shadow", 128'(rdata0), 128'(32'h5));

        // Decode boundaries
        addr = 8'h0F; rd = 1;
        tick();
        chk("lo_miss_valid", 128'(rvalid0), 128'(1));
        chk("lo_miss_data",  128'(rdata0), 128'(0));
        addr = 8'h14;
        tick();
        rd = 0;
        chk("hi_miss_valid", 128'(rvalid0), 128'(1));
        chk("hi_miss_data",  128'(rdata0), 128'(0));
        wdata = 32'hFFFFFFFF; wr = 1;
        tick();
        wr = 0;
        chk("hi_miss_wr_cout", cout0, {32'h33333333, 32'hDEADBEEF, 32'h22222222, 32'h11111111});
        chk("hi_miss_wr_pend", 128'(pend0), 128'(1));
        chk("hi_miss_wr_direct", cout1, {32'h33333333, 32'hDEADBEEF, 32'h5, 32'h11111111});
        addr = 8'h10; wdata = 32'h7; wr = 1;
        tick();
        wr = 0;
        chk("direct_wr0", cout1, {32'h33333333, 32'hDEADBEEF, 32'h5, 32'h7});
        chk("dbuf_wr0_hidden", cout0, {32'h33333333, 32'hDEADBEEF, 32'h22222222, 32'h11111111});

        // Reset mid-operation
        addr = 8'h12; rd = 1;
        tick();
        rd = 0; reset = 1;
        #1;
        chk("rst_mid_valid_a", 128'(rvalid0), 128'(0));
        tick();
        reset = 0;
        chk("rst_mid_valid_b", 128'(rvalid0), 128'(0));
        chk("rst_mid_cout",    cout0, {4{32'hA5}});
        chk("rst_mid_cout_d",  cout1, {4{32'hA5}});
        chk("rst_mid_pend",    128'(pend0), 128'(0));
        chk("rst_mid_rdata",   128'(rdata0), 128'(0));
        rd = 1;
        tick();
        rd = 0;
        chk("rst_mid_shadow", 128'(rdata0), 128'(32'hA5));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
